// File: rtl/mem_responder_if.sv
// Request/response bus between a memory requester and mem_responder.
// The requester drives address, strobe, data and mask; the responder answers.
interface mem_responder_if;
    logic [31:0] memory_address;
    logic        memory_read_strobe;
    logic [31:0] memory_write_data;
    logic [3:0]  memory_write_mask;
    logic [31:0] memory_read_data;
    logic        memory_busy;
    logic        memory_ready;
    logic        memory_error;

    modport master (
        output memory_address, memory_read_strobe, memory_write_data, memory_write_mask,
        input  memory_read_data, memory_busy, memory_ready, memory_error
    );

    modport slave (
        input  memory_address, memory_read_strobe, memory_write_data, memory_write_mask,
        output memory_read_data, memory_busy, memory_ready, memory_error
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word RAM with byte-lane writes behind an IDLE/WAIT/RESPOND handshake
// that inserts WAIT_STATES cycles before each one-cycle ready pulse.
module mem_responder #(
    parameter int WORDS       = 256,
    parameter int WAIT_STATES = 1
) (
    input logic            CLK,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int         AW      = $clog2(WORDS);
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        armed;
    logic [31:0] read_data_q;
    logic        busy_q;
    logic        ready_q;
    logic        error_q;

    logic [31:0] mem [WORDS];

    // Request fields latched at acceptance
    logic [AW-1:0] idx_p0;
    logic [31:0]   wdata_p0;
    logic [3:0]    mask_p0;
    logic          rd_p0;
    logic          oor_p0;

    logic          req_vld;
    logic          in_oor;
    logic [AW-1:0] in_idx;
    logic          accept;
    logic          commit;
    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_mask;
    logic          cur_rd;
    logic          cur_oor;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus.memory_address[1:0];

    assign req_vld = bus.memory_read_strobe | (|bus.memory_write_mask);
    assign in_oor  = |bus.memory_address[31:AW+2];
    assign in_idx  = bus.memory_address[AW+1:2];
    // armed is low for the first edge after reset release, so no request is taken there
    assign accept  = armed && (state == IDLE) && req_vld;

    always_comb begin
        commit = 1'b0;
        if (NO_WAIT)
            commit = accept;
        else
            commit = (state == WAIT) && (cnt == 4'd1);
    end

    // With no wait states the commit edge is the accept edge, so use the live inputs
    always_comb begin
        if (state == IDLE) begin
            cur_idx   = in_idx;
            cur_wdata = bus.memory_write_data;
            cur_mask  = bus.memory_write_mask;
            cur_rd    = bus.memory_read_strobe;
            cur_oor   = in_oor;
        end else begin
            cur_idx   = idx_p0;
            cur_wdata = wdata_p0;
            cur_mask  = mask_p0;
            cur_rd    = rd_p0;
            cur_oor   = oor_p0;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE) begin
            idx_p0   <= in_idx;
            wdata_p0 <= bus.memory_write_data;
            mask_p0  <= bus.memory_write_mask;
            rd_p0    <= bus.memory_read_strobe;
            oor_p0   <= in_oor;
        end
    end

    always_ff @(posedge CLK) begin
        if (commit && !cur_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_mask[b])
                    mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            armed       <= 1'b0;
            read_data_q <= 32'd0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            armed   <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            // Non-blocking RAM write means this read sees the pre-write word
            if (commit) begin
                ready_q <= 1'b1;
                error_q <= cur_oor;
                if (cur_rd)
                    read_data_q <= cur_oor ? 32'd0 : mem[cur_idx];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (NO_WAIT) begin
                            state <= RESPOND;
                        end else begin
                            state <= WAIT;
                            cnt   <= WS_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESPOND;
                end
                RESPOND: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.memory_read_data = read_data_q;
    assign bus.memory_busy      = busy_q;
    assign bus.memory_ready     = ready_q;
    assign bus.memory_error     = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (1, 0 and 3 wait states) share
// one stimulus bus; all but the instance under test are held in reset.
module tb_mem_responder;
    logic        CLK;
    logic [2:0]  rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  mask;
    int          sel;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] o_rdata;
    logic        o_busy;
    logic        o_ready;
    logic        o_error;

    mem_responder_if if0 ();
    mem_responder_if if1 ();
    mem_responder_if if2 ();

    assign if0.memory_address     = addr;
    assign if0.memory_read_strobe = rd;
    assign if0.memory_write_data  = wdata;
    assign if0.memory_write_mask  = mask;
    assign if1.memory_address     = addr;
    assign if1.memory_read_strobe = rd;
    assign if1.memory_write_data  = wdata;
    assign if1.memory_write_mask  = mask;
    assign if2.memory_address     = addr;
    assign if2.memory_read_strobe = rd;
    assign if2.memory_write_data  = wdata;
    assign if2.memory_write_mask  = mask;

    mem_responder #(.WORDS(256), .WAIT_STATES(1)) u0 (.CLK(CLK), .reset(rst_n[0]), .bus(if0));
    mem_responder #(.WORDS(256), .WAIT_STATES(0)) u1 (.CLK(CLK), .reset(rst_n[1]), .bus(if1));
    mem_responder #(.WORDS(256), .WAIT_STATES(3)) u2 (.CLK(CLK), .reset(rst_n[2]), .bus(if2));

    always_comb begin
        case (sel)
            0: begin
                o_rdata = if0.memory_read_data; o_busy = if0.memory_busy;
                o_ready = if0.memory_ready;     o_error = if0.memory_error;
            end
            1: begin
                o_rdata = if1.memory_read_data; o_busy = if1.memory_busy;
                o_ready = if1.memory_ready;     o_error = if1.memory_error;
            end
            default: begin
                o_rdata = if2.memory_read_data; o_busy = if2.memory_busy;
                o_ready = if2.memory_ready;     o_error = if2.memory_error;
            end
        endcase
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Presents one request for a single edge, then scrambles the inputs while it is
    // in flight and checks the ready timing, error flag and read data.
    task automatic do_req(input string tag, input logic [31:0] a, input logic r,
                          input logic [31:0] wd, input logic [3:0] m, input int ws,
                          input logic exp_err, input logic [31:0] exp_rd);
        addr = a; rd = r; wdata = wd; mask = m;
        tick;
        addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD; rd = 1'b0; mask = 4'h0;
        check({tag, " busy"}, 32'(o_busy), 32'd1);
        for (int k = 0; k < ws; k++) begin
            check({tag, " early_ready"}, 32'(o_ready), 32'd0);
            tick;
        end
        check({tag, " ready"}, 32'(o_ready), 32'd1);
        check({tag, " error"}, 32'(o_error), 32'(exp_err));
        check({tag, " rdata"}, o_rdata, exp_rd);
        tick;
        check({tag, " ready_drop"}, 32'(o_ready), 32'd0);
        check({tag, " error_drop"}, 32'(o_error), 32'd0);
        check({tag, " busy_drop"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        rst_n = 3'b000;
        addr = 32'd0; wdata = 32'd0; rd = 1'b0; mask = 4'h0; sel = 0;
        tick;
        tick;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset rdata", o_rdata, 32'd0);
            check("reset busy", 32'(o_busy), 32'd0);
            check("reset ready", 32'(o_ready), 32'd0);
            check("reset error", 32'(o_error), 32'd0);
        end

        // One wait state: full-word write, read back, byte-lane merge, range checks
        sel = 0;
        rst_n[0] = 1'b1;
        tick;
        tick;
        do_req("ws1 wr10", 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 32'h0);
        do_req("ws1 rd10", 32'h10, 1'b1, 32'h0, 4'h0, 1, 1'b0, 32'hDEAD_BEEF);
        do_req("ws1 wrlane", 32'h10, 1'b0, 32'h0000_5500, 4'b0010, 1, 1'b0, 32'hDEAD_BEEF);
        do_req("ws1 rdlane", 32'h10, 1'b1, 32'h0, 4'h0, 1, 1'b0, 32'hDEAD_55EF);
        do_req("ws1 rd13", 32'h13, 1'b1, 32'h0, 4'h0, 1, 1'b0, 32'hDEAD_55EF);
        do_req("ws1 wr00", 32'h0, 1'b0, 32'h1122_3344, 4'hF, 1, 1'b0, 32'hDEAD_55EF);
        do_req("ws1 rd400", 32'h400, 1'b1, 32'h0, 4'h0, 1, 1'b1, 32'h0);
        do_req("ws1 wr400", 32'h400, 1'b0, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0);
        do_req("ws1 rd00", 32'h0, 1'b1, 32'h0, 4'h0, 1, 1'b0, 32'h1122_3344);
        rst_n[0] = 1'b0;

        // No wait states: simultaneous read and write returns the old word
        sel = 1;
        rst_n[1] = 1'b1;
        tick;
        tick;
        do_req("ws0 wr20", 32'h20, 1'b0, 32'hAAAA_AAAA, 4'hF, 0, 1'b0, 32'h0);
        do_req("ws0 rdwr20", 32'h20, 1'b1, 32'h1234_5678, 4'hF, 0, 1'b0, 32'hAAAA_AAAA);
        do_req("ws0 rd20", 32'h20, 1'b1, 32'h0, 4'h0, 0, 1'b0, 32'h1234_5678);
        rst_n[1] = 1'b0;

        // Three wait states: a request held during busy is dropped
        sel = 2;
        rst_n[2] = 1'b1;
        tick;
        tick;
        do_req("ws3 wr34", 32'h34, 1'b0, 32'h3434_3434, 4'hF, 3, 1'b0, 32'h0);
        addr = 32'h30; rd = 1'b0; wdata = 32'h0000_00A1; mask = 4'hF;
        tick;
        addr = 32'h34; rd = 1'b1; wdata = 32'hBBBB_BBBB; mask = 4'hF;
        check("held busy1", 32'(o_busy), 32'd1);
        tick;
        check("held ready2", 32'(o_ready), 32'd0);
        tick;
        check("held ready3", 32'(o_ready), 32'd0);
        tick;
        check("held ready4", 32'(o_ready), 32'd1);
        check("held rdata", o_rdata, 32'h0);
        tick;
        check("held busy5", 32'(o_busy), 32'd0);
        check("held ready5", 32'(o_ready), 32'd0);
        rd = 1'b0; mask = 4'h0;
        tick;
        check("held idle", 32'(o_busy), 32'd0);
        do_req("ws3 rd34", 32'h34, 1'b1, 32'h0, 4'h0, 3, 1'b0, 32'h3434_3434);
        do_req("ws3 rd30", 32'h30, 1'b1, 32'h0, 4'h0, 3, 1'b0, 32'h0000_00A1);

        // Reset during WAIT aborts the write and clears outputs without a clock
        do_req("ws3 wr08", 32'h8, 1'b0, 32'h0000_0077, 4'hF, 3, 1'b0, 32'h0000_00A1);
        addr = 32'h8; rd = 1'b0; wdata = 32'h0000_0055; mask = 4'hF;
        tick;
        rd = 1'b0; mask = 4'h0;
        tick;
        check("abort busy_pre", 32'(o_busy), 32'd1);
        rst_n[2] = 1'b0;
        #1;
        check("abort rdata", o_rdata, 32'h0);
        check("abort busy", 32'(o_busy), 32'd0);
        check("abort ready", 32'(o_ready), 32'd0);
        check("abort error", 32'(o_error), 32'd0);
        tick;
        tick;
        tick;
        rst_n[2] = 1'b1;
        tick;
        tick;
        do_req("ws3 rd08", 32'h8, 1'b1, 32'h0, 4'h0, 3, 1'b0, 32'h0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
